// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
//
// Operand-fetch / issue stage that sits directly in front of a 32-bit
// combinational ALU. It holds a 2-read / 1-write register file, accepts
// operations over a valid/ready request port and drives the ALU inputs
// from registers. One cycle later it captures the ALU result and retires
// it over a valid/ready response port.
//
// Pipeline:
//   EX : ex_valid, alu_a, alu_b, alu_op, ex_rd   (ALU evaluates during EX)
//   WB : rsp_valid, rsp_rd, rsp_data             (written back on rsp handshake)
//
// Operands are bypassed from EX (live alu_result) and from WB (rsp_data),
// so dependent back-to-back operations issue without a bubble.
//
// Optional feature, selected by the macro ALU_IMM_EN:
//   When defined, ports req_use_imm / req_imm exist. With req_use_imm=1,
//   operand B is req_imm sign-extended to DATA_W and rs2 is ignored.
//   When undefined (default), B always comes from the rs2 path.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   cfg_we/cfg_addr/cfg_data    register-file preload write (r0 ignored)
//   req_valid/req_ready         op request handshake
//   req_op/req_rs1/req_rs2/req_rd  op fields (ALUOp, sources, destination)
//   req_use_imm/req_imm         immediate operand (ALU_IMM_EN only)
//   alu_a/alu_b/alu_op          registered ALU inputs
//   alu_result                  combinational ALU result
//   rsp_valid/rsp_ready         retire handshake
//   rsp_rd/rsp_data             retired destination and result
// ---------------------------------------------------------------------------
module alu_issue_stage #(
    parameter int DATA_W = 32,
    parameter int REG_N  = 32,
    parameter int IMM_W  = 16,
    localparam int AW    = $clog2(REG_N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [AW-1:0]     cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [AW-1:0]     req_rs1,
    input  logic [AW-1:0]     req_rs2,
    input  logic [AW-1:0]     req_rd,
`ifdef ALU_IMM_EN
    input  logic              req_use_imm,
    input  logic [IMM_W-1:0]  req_imm,
`endif
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [AW-1:0]     rsp_rd,
    output logic [DATA_W-1:0] rsp_data
);

    logic              ex_valid;
    logic [AW-1:0]     ex_rd;
    logic [DATA_W-1:0] regs [REG_N];

    logic wb_adv;
    logic ex_adv;
    logic accept;
    logic wb_we;

    assign wb_adv    = !rsp_valid || rsp_ready;
    assign ex_adv    = ex_valid && wb_adv;
    assign req_ready = !ex_valid || wb_adv;
    assign accept    = req_valid && req_ready;
    assign wb_we     = rsp_valid && rsp_ready && (rsp_rd != '0);

    // Operand selection with bypass. The youngest in-flight producer (EX)
    // wins over the older one (WB), which wins over the register file.
    // r0 is checked first so an in-flight op targeting r0 never leaks.
    function automatic logic [DATA_W-1:0] fetch(
        input logic [AW-1:0]     rs,
        input logic              exv,
        input logic [AW-1:0]     exrd,
        input logic [DATA_W-1:0] exres,
        input logic              wbv,
        input logic [AW-1:0]     wbrd,
        input logic [DATA_W-1:0] wbres,
        input logic [DATA_W-1:0] rfval
    );
        logic [DATA_W-1:0] val;
        if (rs == '0)
            val = '0;
        else if (exv && (exrd == rs))
            val = exres;
        else if (wbv && (wbrd == rs))
            val = wbres;
        else
            val = rfval;
        return val;
    endfunction

    logic [DATA_W-1:0] opnd_a;
    logic [DATA_W-1:0] opnd_b;

    assign opnd_a = fetch(req_rs1, ex_valid, ex_rd, alu_result,
                          rsp_valid, rsp_rd, rsp_data, regs[req_rs1]);
    assign opnd_b = fetch(req_rs2, ex_valid, ex_rd, alu_result,
                          rsp_valid, rsp_rd, rsp_data, regs[req_rs2]);

    // Immediate path. In the default build the immediate is tied off and
    // never selected, so operand B always follows rs2.
    logic              use_imm;
    logic [IMM_W-1:0]  imm_raw;
    logic [DATA_W-1:0] imm_ext;

`ifdef ALU_IMM_EN
    assign use_imm = req_use_imm;
    assign imm_raw = req_imm;
`else
    assign use_imm = 1'b0;
    assign imm_raw = '0;
`endif

    assign imm_ext = {{(DATA_W-IMM_W){imm_raw[IMM_W-1]}}, imm_raw};

    // EX and WB pipeline registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid  <= 1'b0;
            ex_rd     <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= 3'b000;
            rsp_valid <= 1'b0;
            rsp_rd    <= '0;
            rsp_data  <= '0;
        end else begin
            if (ex_adv) begin
                rsp_valid <= 1'b1;
                rsp_rd    <= ex_rd;
                rsp_data  <= alu_result;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end

            // ALU inputs hold their last values when nothing is accepted.
            if (accept) begin
                ex_valid <= 1'b1;
                ex_rd    <= req_rd;
                alu_a    <= opnd_a;
                alu_b    <= use_imm ? imm_ext : opnd_b;
                alu_op   <= req_op;
            end else if (ex_adv) begin
                ex_valid <= 1'b0;
            end
        end
    end

    // Register file. The writeback assignment follows the preload one so
    // that it wins when both target the same register on the same edge.
    // r0 is never written and stays at its reset value of zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_N; i++)
                regs[i] <= '0;
        end else begin
            if (cfg_we && (cfg_addr != '0))
                regs[cfg_addr] <= cfg_data;
            if (wb_we)
                regs[rsp_rd] <= rsp_data;
        end
    end

endmodule
